register_monitor: RTL

- Synthesizable on-chip checker for the enabled `register` block.
- Sits beside a `register` instance and observes its en/in/out. Each cycle it predicts out from the previous cycle's en/in/out and counts mismatches.
- Records the first failure and can halt after an error limit.
- Provides the hardware read-back side of the existing stimulus driver, so a register can be self-checked in silicon or in a bench without a behavioural checker.

---
 rtl/register_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/register_monitor.sv
// Hardware checker for an enabled register: predicts each output from the previous
// cycle's en/in/out, counts checks and mismatches, and keeps the first failure.
module register_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter int ERR_LIMIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mon_en,
  input  logic [WIDTH-1:0]     mon_in,
  input  logic [WIDTH-1:0]     mon_out,
  output logic                 active,
  output logic                 halted,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] check_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_expected,
  output logic [WIDTH-1:0]     first_err_actual
);

  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(ERR_LIMIT);
  localparam bit                   LIMIT_EN = (ERR_LIMIT != 0);

  state_t               state, state_nxt;
  logic                 prev_en, prev_en_nxt;
  logic [WIDTH-1:0]     prev_in, prev_in_nxt;
  logic [WIDTH-1:0]     prev_out, prev_out_nxt;
  logic                 err_nxt;
  logic [CNT_WIDTH-1:0] check_count_nxt, err_count_nxt;
  logic                 first_err_valid_nxt;
  logic [WIDTH-1:0]     first_err_expected_nxt, first_err_actual_nxt;

  logic [WIDTH-1:0]     expected;
  logic [CNT_WIDTH-1:0] check_inc, err_inc;

  // Prediction from the previous cycle; counters saturate instead of wrapping.
  assign expected  = prev_en ? prev_in : prev_out;
  assign check_inc = (check_count == CNT_MAX) ? check_count : check_count + CNT_ONE;
  assign err_inc   = (err_count == CNT_MAX) ? err_count : err_count + CNT_ONE;

  assign active = (state == CHECK);
  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      prev_en            <= 1'b0;
      prev_in            <= '0;
      prev_out           <= '0;
      err                <= 1'b0;
      check_count        <= '0;
      err_count          <= '0;
      first_err_valid    <= 1'b0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
    end else begin
      state              <= state_nxt;
      prev_en            <= prev_en_nxt;
      prev_in            <= prev_in_nxt;
      prev_out           <= prev_out_nxt;
      err                <= err_nxt;
      check_count        <= check_count_nxt;
      err_count          <= err_count_nxt;
      first_err_valid    <= first_err_valid_nxt;
      first_err_expected <= first_err_expected_nxt;
      first_err_actual   <= first_err_actual_nxt;
    end
  end

  // start takes priority over stop in every state and always re-arms with fresh statistics.
  always_comb begin
    state_nxt              = state;
    prev_en_nxt            = prev_en;
    prev_in_nxt            = prev_in;
    prev_out_nxt           = prev_out;
    err_nxt                = 1'b0;
    check_count_nxt        = check_count;
    err_count_nxt          = err_count;
    first_err_valid_nxt    = first_err_valid;
    first_err_expected_nxt = first_err_expected;
    first_err_actual_nxt   = first_err_actual;

    if (start) begin
      state_nxt              = CHECK;
      prev_en_nxt            = mon_en;
      prev_in_nxt            = mon_in;
      prev_out_nxt           = mon_out;
      check_count_nxt        = '0;
      err_count_nxt          = '0;
      first_err_valid_nxt    = 1'b0;
      first_err_expected_nxt = '0;
      first_err_actual_nxt   = '0;
    end else begin
      case (state)
        CHECK: begin
          if (stop) begin
            state_nxt = IDLE;
          end else begin
            check_count_nxt = check_inc;
            prev_en_nxt     = mon_en;
            prev_in_nxt     = mon_in;
            prev_out_nxt    = mon_out;
            if (mon_out != expected) begin
              err_nxt       = 1'b1;
              err_count_nxt = err_inc;
              if (!first_err_valid) begin
                first_err_valid_nxt    = 1'b1;
                first_err_expected_nxt = expected;
                first_err_actual_nxt   = mon_out;
              end
              if (LIMIT_EN && (err_inc == LIMIT)) begin
                state_nxt = HALT;
              end
            end
          end
        end
        HALT: begin
          if (stop) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

endmodule
